conv_frame_writer: RTL and testbench

//  Sink end of the single-channel pixel stream produced by the 3x3 convolution stage.

---
 rtl/conv_frame_writer_if.sv | 25 ++
 rtl/conv_frame_writer.sv | 140 ++++++++++++++
 tb/tb_conv_frame_writer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/conv_frame_writer_if.sv
// Pixel-stream input and frame-buffer write-port bundle for conv_frame_writer.
interface conv_frame_writer_if #(
  parameter int PIXEL_WIDTH = 8,
  parameter int ADDR_WIDTH  = 12
);
  logic                   start;
  logic                   abort;
  logic                   pixel_valid;
  logic [PIXEL_WIDTH-1:0] pixel_in;
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [PIXEL_WIDTH-1:0] mem_wdata;
  logic                   busy;
  logic                   frame_done;

  modport master (
    output start, abort, pixel_valid, pixel_in,
    input  mem_we, mem_addr, mem_wdata, busy, frame_done
  );

  modport slave (
    input  start, abort, pixel_valid, pixel_in,
    output mem_we, mem_addr, mem_wdata, busy, frame_done
  );
endinterface

// File: rtl/conv_frame_writer.sv
// Drops conv warm-up pixels, raster-writes one frame to the frame buffer, pulses frame_done.
// Optional BORDER_ZERO_EN: border pixels are written as zero.
module conv_frame_writer #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 64,
  parameter int IMG_HEIGHT  = 64,
  parameter int SKIP        = 5,
  parameter int ADDR_WIDTH  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_frame_writer_if.slave   bus
);
  localparam int XW  = $clog2(IMG_WIDTH);
  localparam int YW  = $clog2(IMG_HEIGHT);
  localparam int SKW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_WRITE
  } state_t;

  state_t                 state_q, state_d;
  logic [SKW-1:0]         skip_cnt_q, skip_cnt_d;
  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [PIXEL_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                   frame_done_q, frame_done_d;
  logic [PIXEL_WIDTH-1:0] wr_pixel;

`ifdef BORDER_ZERO_EN
  logic border;
  always_comb begin
    border = (x_q == '0) || (x_q == XW'(IMG_WIDTH - 1)) ||
             (y_q == '0) || (y_q == YW'(IMG_HEIGHT - 1));
    wr_pixel = border ? '0 : bus.pixel_in;
  end
`else
  always_comb wr_pixel = bus.pixel_in;
`endif

  always_comb begin
    state_d      = state_q;
    skip_cnt_d   = skip_cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    mem_we_d     = 1'b0;
    frame_done_d = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    if (bus.abort) begin
      state_d    = ST_IDLE;
      skip_cnt_d = '0;
      x_d        = '0;
      y_d        = '0;
      addr_d     = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
            if (SKIP == 0) begin
              state_d = ST_WRITE;
            end else begin
              state_d    = ST_SKIP;
              skip_cnt_d = SKW'(SKIP);
            end
          end
        end
        ST_SKIP: begin
          if (bus.pixel_valid) begin
            skip_cnt_d = skip_cnt_q - 1'b1;
            if (skip_cnt_q == SKW'(1)) state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (bus.pixel_valid) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = wr_pixel;
            addr_d      = addr_q + 1'b1;
            if (x_q == XW'(IMG_WIDTH - 1)) begin
              x_d = '0;
              // Final pixel: return to IDLE on the same edge that registers its write.
              if (y_q == YW'(IMG_HEIGHT - 1)) begin
                frame_done_d = 1'b1;
                state_d      = ST_IDLE;
                y_d          = '0;
                addr_d       = '0;
              end else begin
                y_d = y_q + 1'b1;
              end
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      skip_cnt_q   <= '0;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      skip_cnt_q   <= skip_cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_conv_frame_writer.sv
// Directed bench for conv_frame_writer on a 4x3 frame with 5 warm-up pixels.
module tb_conv_frame_writer;
  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int SK = 5;
  localparam int AW = 4;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_frame_writer_if #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) bus ();

  conv_frame_writer #(
    .PIXEL_WIDTH (PW),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .SKIP        (SK),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_seen   = 0;
  bit          armed    = 1'b0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int unsigned exp_pix(input int unsigned a, input int unsigned d);
`ifdef BORDER_ZERO_EN
    int unsigned x, y;
    x = a % W;
    y = a / W;
    if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 0;
`endif
    return d & 8'hFF;
  endfunction

  // One clock of stimulus; checks the write port against the reference sequence.
  task automatic push(input bit v, input int unsigned d);
    bit          exp_we;
    bit          exp_done;
    int unsigned a;
    bus.pixel_valid = v;
    bus.pixel_in    = d[PW-1:0];
    @(posedge clk); #1;
    bus.pixel_valid = 1'b0;
    exp_we   = 1'b0;
    exp_done = 1'b0;
    a        = 0;
    if (v && armed) begin
      if (n_seen >= SK) begin
        a        = n_seen - SK;
        exp_we   = 1'b1;
        exp_done = (a == NPIX - 1);
        if (exp_done) armed = 1'b0;
      end
      n_seen++;
    end
    check("mem_we", bus.mem_we, exp_we);
    check("frame_done", bus.frame_done, exp_done);
    check("busy", bus.busy, armed);
    if (exp_we) begin
      check("mem_addr", bus.mem_addr, a);
      check("mem_wdata", bus.mem_wdata, exp_pix(a, d));
    end
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (!armed) begin
      armed  = 1'b1;
      n_seen = 0;
    end
    check("busy_after_start", bus.busy, armed);
  endtask

  task automatic stream(input int unsigned base, input bit gaps);
    do_start();
    for (int i = 0; i < SK + NPIX; i++) begin
      push(1'b1, base + i);
      if (gaps) push(1'b0, 8'hEE);
    end
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.pixel_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", bus.mem_we, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.frame_done, 0);
    rst = 1'b0;

    // Valid pixels in IDLE are ignored.
    push(1'b1, 8'h33);
    push(1'b1, 8'h34);

    // Back-to-back frame, then a trailing pixel dropped in IDLE.
    stream(0, 1'b0);
    push(1'b0, 0);
    push(1'b1, 99);

    // Frame with valid low every other cycle.
    stream(0, 1'b1);

    // Abort while the addr-6 write is on the port.
    do_start();
    for (int i = 0; i < SK + 7; i++) push(1'b1, i);
    bus.abort       = 1'b1;
    bus.pixel_valid = 1'b1;
    bus.pixel_in    = 8'd12;
    @(posedge clk); #1;
    bus.abort       = 1'b0;
    bus.pixel_valid = 1'b0;
    armed = 1'b0;
    check("abort_we", bus.mem_we, 0);
    check("abort_done", bus.frame_done, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_addr_hold", bus.mem_addr, 6);
    for (int i = 13; i < 17; i++) push(1'b1, i);
    stream(0, 1'b0);

    // start and abort together from IDLE: abort wins.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_busy", bus.busy, 0);

    // Restart attempt mid-frame is ignored.
    do_start();
    for (int i = 0; i < SK + NPIX; i++) begin
      if (i == 10) bus.start = 1'b1;
      push(1'b1, i);
      bus.start = 1'b0;
    end

    // Border-pattern data set.
    stream(100, 1'b0);

    // Reset mid-WRITE.
    do_start();
    for (int i = 0; i < SK + 5; i++) push(1'b1, i);
    rst             = 1'b1;
    bus.pixel_valid = 1'b1;
    bus.pixel_in    = 8'd10;
    @(posedge clk); #1;
    rst             = 1'b0;
    bus.pixel_valid = 1'b0;
    armed = 1'b0;
    check("mrst_we", bus.mem_we, 0);
    check("mrst_addr", bus.mem_addr, 0);
    check("mrst_wdata", bus.mem_wdata, 0);
    check("mrst_busy", bus.busy, 0);
    check("mrst_done", bus.frame_done, 0);
    push(1'b1, 11);
    push(1'b1, 12);
    stream(0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
